// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU result types and constants
package fpu_pkg;

    localparam int FPU_TAG_W = 5;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]          y;
        logic                 ovf;
        logic                 unf;
        logic [FPU_TAG_W-1:0] rd;
    } fp_result_t;

endpackage

// File: rtl/fpu_sync_fifo.sv
// rtl/fpu_sync_fifo.sv - generic synchronous FIFO shared by the FPU result buffers
module fpu_sync_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    input  T                         i_wr_data,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output T                         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_push;
    logic w_pop;

    // Ready/valid come only from the registered count, so no ready-to-ready path exists.
    assign o_wr_ready = (r_count != CNT_W'(DEPTH));
    assign o_rd_valid = (r_count != '0);
    assign w_push     = i_wr_valid && o_wr_ready;
    assign w_pop      = o_rd_valid && i_rd_ready;
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fmul_result_buf.sv
// rtl/fmul_result_buf.sv - fmul result FIFO with sticky overflow/underflow status
module fmul_result_buf
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = FPU_TAG_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_y,
    input  logic                   in_ovf,
    input  logic                   in_unf,
    input  logic [TAG_W-1:0]       in_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_y,
    output logic                   out_ovf,
    output logic                   out_unf,
    output logic [TAG_W-1:0]       out_rd,
    output logic                   flag_ovf,
    output logic                   flag_unf,
    input  logic                   flag_clr,
    output logic [$clog2(DEPTH):0] count
);

    fp_result_t w_in_res;
    fp_result_t w_out_res;
    logic       w_push;
    logic       r_flag_ovf;
    logic       r_flag_unf;

    assign w_in_res = '{y: in_y, ovf: in_ovf, unf: in_unf, rd: in_rd};

    fpu_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fp_result_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_valid (in_valid),
        .o_wr_ready (in_ready),
        .i_wr_data  (w_in_res),
        .o_rd_valid (out_valid),
        .i_rd_ready (out_ready),
        .o_rd_data  (w_out_res),
        .o_count    (count)
    );

    assign out_y   = w_out_res.y;
    assign out_ovf = w_out_res.ovf;
    assign out_unf = w_out_res.unf;
    assign out_rd  = w_out_res.rd;

    assign w_push = in_valid && in_ready;

    // A flag-setting push in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag_ovf <= 1'b0;
            r_flag_unf <= 1'b0;
        end else begin
            r_flag_ovf <= (r_flag_ovf && !flag_clr) || (w_push && in_ovf);
            r_flag_unf <= (r_flag_unf && !flag_clr) || (w_push && in_unf);
        end
    end

    assign flag_ovf = r_flag_ovf;
    assign flag_unf = r_flag_unf;

endmodule

// File: tb/tb_fmul_result_buf.sv
// tb/tb_fmul_result_buf.sv - scoreboard bench for fmul_result_buf
module tb_fmul_result_buf;
    import fpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_y;
    logic             in_ovf;
    logic             in_unf;
    logic [TAG_W-1:0] in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic             out_ovf;
    logic             out_unf;
    logic [TAG_W-1:0] out_rd;
    logic             flag_ovf;
    logic             flag_unf;
    logic             flag_clr;
    logic [2:0]       count;

    fmul_result_buf #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_ovf    (in_ovf),
        .in_unf    (in_unf),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_rd    (out_rd),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_clr  (flag_clr),
        .count     (count)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_bad   = 0;
    fp_result_t sb[$];
    int         m_cnt   = 0;
    logic       m_fovf  = 1'b0;
    logic       m_funf  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called #1 after an edge with inputs already set; checks state, then advances one clock.
    task automatic tick();
        logic       pu;
        logic       po;
        fp_result_t e;
        pu = in_valid && (m_cnt != DEPTH);
        po = out_ready && (m_cnt != 0);
        chk("in_ready", in_ready, m_cnt != DEPTH);
        chk("out_valid", out_valid, m_cnt != 0);
        chk("count", count, m_cnt);
        if (m_cnt != 0) begin
            chk("out_y", out_y, sb[0].y);
            chk("out_rd", out_rd, sb[0].rd);
            chk("out_ovf", out_ovf, sb[0].ovf);
            chk("out_unf", out_unf, sb[0].unf);
        end
        if (po) void'(sb.pop_front());
        if (pu) begin
            e.y = in_y; e.ovf = in_ovf; e.unf = in_unf; e.rd = in_rd;
            sb.push_back(e);
        end
        m_fovf = (m_fovf && !flag_clr) || (pu && in_ovf);
        m_funf = (m_funf && !flag_clr) || (pu && in_unf);
        @(posedge clk);
        #1;
        m_cnt = m_cnt + int'(pu) - int'(po);
        chk("flag_ovf", flag_ovf, m_fovf);
        chk("flag_unf", flag_unf, m_funf);
    endtask

    task automatic drive(input logic v, input logic [31:0] y, input logic [4:0] rd,
                         input logic ov, input logic un, input logic ordy, input logic clr);
        in_valid = v; in_y = y; in_rd = rd; in_ovf = ov; in_unf = un;
        out_ready = ordy; flag_clr = clr;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_in_ready"}, in_ready, 1'b1);
        chk({pfx, "_out_valid"}, out_valid, 1'b0);
        chk({pfx, "_count"}, count, 0);
        chk({pfx, "_out_y"}, out_y, FP_ZERO);
        chk({pfx, "_out_ovf"}, out_ovf, 1'b0);
        chk({pfx, "_out_unf"}, out_unf, 1'b0);
        chk({pfx, "_out_rd"}, out_rd, 0);
        chk({pfx, "_flag_ovf"}, flag_ovf, 1'b0);
        chk({pfx, "_flag_unf"}, flag_unf, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_vals("rst0");
        tick();

        // Single push into an empty buffer with writeback ready.
        drive(1'b1, 32'h3f80_0000, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lat_out_y", out_y, 32'h3f80_0000);
        chk("lat_out_rd", out_rd, 3);
        tick();
        chk("lat_count", count, 0);

        // Fill past full with writeback stalled; fifth push must be refused.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'(i), 5'(i + 8), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("full_in_ready", in_ready, 1'b0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain_first_y", out_y, 32'd1);
        tick();
        chk("ready_after_pop", in_ready, 1'b1);
        repeat (4) tick();
        chk("drain_empty_count", count, 0);

        // Sticky flags: set, hold, clear, then clear racing a set.
        drive(1'b1, 32'h7f80_0000, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        chk("ovf_held", flag_ovf, 1'b1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("ovf_cleared", flag_ovf, 1'b0);
        drive(1'b1, 32'h0000_0001, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0002, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("unf_set_wins", flag_unf, 1'b1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();

        // Steady push+pop at count=2 long enough to wrap both pointers twice.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            chk("stream_count", count, 2);
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();

        // Asynchronous reset mid-operation with count=3 and flag_ovf set.
        drive(1'b1, 32'h4000_0000, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h4040_0000, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", count, 3);
        chk("pre_rst_ovf", flag_ovf, 1'b1);
        rst = 1'b1;
        #2;
        chk_reset_vals("arst");
        #3;
        rst = 1'b0;
        sb.delete();
        m_cnt = 0; m_fovf = 1'b0; m_funf = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("post_arst");
        drive(1'b1, 32'h3f00_0000, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
